// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_controller
// Description : Moore-style main controller for a multi-cycle processor
//               datapath. Sequences FETCH / DECODE / EXECUTE / MEMORY /
//               WRITEBACK steps per instruction class and stretches the
//               memory-access states to MEM_LAT cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_LAT     memory access latency in cycles (1..8)
// Ports
//   CLK         rising-edge clock
//   RESET       asynchronous active-high reset
//   Op[3:0]     opcode of the instruction held in the IR
//   Zero        ALU zero flag (used by BEQ)
//   PCWrite     program counter write enable
//   IRWrite     instruction register write enable
//   MemWrite    memory write enable
//   RegWrite    register file write enable
//   AdrSrc      memory address select (0 = PC, 1 = ALU result)
//   ALUSrcA     ALU operand A select (0 = PC, 1 = register A)
//   ALUSrcB     ALU operand B select (00 reg B, 01 imm, 10 const 4)
//   ALUControl  ALU operation (00 add, 01 sub, 10 and, 11 or)
//   ResultSrc   4:1 result mux select (00 ALUOut, 01 data, 10 ALU result)
//   State[3:0]  current state code, for debug
// ============================================================================
module multi_cycle_controller #(
    parameter int MEM_LAT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] Op,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic [3:0] State
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_fetch  = 4'd0;
    localparam logic [3:0] c_decode = 4'd1;
    localparam logic [3:0] c_exec_r = 4'd2;
    localparam logic [3:0] c_exec_m = 4'd3;
    localparam logic [3:0] c_mem_rd = 4'd4;
    localparam logic [3:0] c_mem_wr = 4'd5;
    localparam logic [3:0] c_wb_r   = 4'd6;
    localparam logic [3:0] c_wb_m   = 4'd7;
    localparam logic [3:0] c_branch = 4'd8;
    localparam logic [3:0] c_halt   = 4'd9;

    // Opcodes with dedicated handling
    localparam logic [3:0] c_op_ldr  = 4'b0100;
    localparam logic [3:0] c_op_str  = 4'b0101;
    localparam logic [3:0] c_op_b    = 4'b0110;
    localparam logic [3:0] c_op_beq  = 4'b0111;
    localparam logic [3:0] c_op_halt = 4'b1111;

    // Last count value of a stretched memory state (Cnt runs 0..MEM_LAT-1)
    localparam logic [2:0] c_last_cnt = 3'(MEM_LAT - 1);

    // ------------------------------------------------------------------------
    // Registers and combinational nets
    // ------------------------------------------------------------------------
    logic [3:0] r_state;
    logic [2:0] r_cnt;
    logic [3:0] w_next_state;
    logic [2:0] w_next_cnt;

    logic       w_is_rtype;
    logic       w_is_mem;
    logic       w_is_branch;
    logic       w_is_halt;
    logic       w_cnt_done;
    logic       w_counting;

    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_adr_src;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_control;
    logic [1:0] w_result_src;

    // ------------------------------------------------------------------------
    // Opcode class decode
    // ------------------------------------------------------------------------
    assign w_is_rtype  = (Op[3:2] == 2'b00);
    assign w_is_mem    = (Op == c_op_ldr) || (Op == c_op_str);
    assign w_is_branch = (Op == c_op_b)   || (Op == c_op_beq);
    assign w_is_halt   = (Op == c_op_halt);

    assign w_cnt_done  = (r_cnt == c_last_cnt);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = c_fetch;
        case (r_state)
            c_fetch:  w_next_state = w_cnt_done ? c_decode : c_fetch;
            c_decode: begin
                if (w_is_rtype)       w_next_state = c_exec_r;
                else if (w_is_mem)    w_next_state = c_exec_m;
                else if (w_is_branch) w_next_state = c_branch;
                else if (w_is_halt)   w_next_state = c_halt;
                else                  w_next_state = c_fetch;
            end
            c_exec_r: w_next_state = c_wb_r;
            c_exec_m: begin
                // Only LDR/STR can reach EXEC_M; anything else recovers to FETCH.
                if (Op == c_op_ldr)      w_next_state = c_mem_rd;
                else if (Op == c_op_str) w_next_state = c_mem_wr;
                else                     w_next_state = c_fetch;
            end
            c_mem_rd: w_next_state = w_cnt_done ? c_wb_m : c_mem_rd;
            c_mem_wr: w_next_state = c_fetch;
            c_wb_r:   w_next_state = c_fetch;
            c_wb_m:   w_next_state = c_fetch;
            c_branch: w_next_state = c_fetch;
            c_halt:   w_next_state = c_halt;
            default:  w_next_state = c_fetch;
        endcase
    end

    // Cnt only advances while staying in a stretched state; any state change
    // (including entry into FETCH or MEM_RD) starts it from zero.
    assign w_counting = (w_next_state == r_state) &&
                        ((r_state == c_fetch) || (r_state == c_mem_rd));
    assign w_next_cnt = w_counting ? (r_cnt + 3'd1) : 3'd0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= c_fetch;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode (BRANCH PCWrite additionally looks at Op/Zero)
    // ------------------------------------------------------------------------
    always_comb begin
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_adr_src     = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_alu_control = 2'b00;
        w_result_src  = 2'b00;
        case (r_state)
            c_fetch: begin
                // PC + 4 computed through the ALU and fed straight to the PC
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = w_cnt_done;
                w_pc_write   = w_cnt_done;
            end
            c_decode: begin
                w_alu_src_b = 2'b01;
            end
            c_exec_r: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = Op[1:0];
            end
            c_exec_m: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b01;
            end
            c_mem_rd: begin
                w_adr_src = 1'b1;
            end
            c_mem_wr: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_wb_r: begin
                w_reg_write = 1'b1;
            end
            c_wb_m: begin
                w_reg_write  = 1'b1;
                w_result_src = 2'b01;
            end
            c_branch: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = 2'b01;
                w_pc_write    = (Op == c_op_b) || ((Op == c_op_beq) && Zero);
            end
            default: begin
                // HALT and unused codes keep every default
            end
        endcase
    end

    // Reset masks the enables combinationally: with MEM_LAT=1 the reset
    // state is already the last FETCH cycle, which would otherwise raise
    // IRWrite/PCWrite while RESET is still held.
    assign PCWrite    = w_pc_write  & ~RESET;
    assign IRWrite    = w_ir_write  & ~RESET;
    assign MemWrite   = w_mem_write & ~RESET;
    assign RegWrite   = w_reg_write & ~RESET;
    assign AdrSrc     = w_adr_src;
    assign ALUSrcA    = w_alu_src_a;
    assign ALUSrcB    = w_alu_src_b;
    assign ALUControl = w_alu_control;
    assign ResultSrc  = w_result_src;
    assign State      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_controller
// Description : Directed self-checking bench for multi_cycle_controller.
//               Two instances (MEM_LAT=1 and MEM_LAT=3) are traced cycle by
//               cycle against hand-computed output vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_controller;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- instance with MEM_LAT = 1 ----------------
    logic       rst1 = 1'b1;
    logic [3:0] op1  = 4'd0;
    logic       zero1 = 1'b0;
    logic       pcw1, irw1, mw1, rw1, adr1, sa1;
    logic [1:0] sb1, ac1, rs1;
    logic [3:0] st1;

    multi_cycle_controller #(.MEM_LAT(1)) u_dut1 (
        .CLK(CLK), .RESET(rst1), .Op(op1), .Zero(zero1),
        .PCWrite(pcw1), .IRWrite(irw1), .MemWrite(mw1), .RegWrite(rw1),
        .AdrSrc(adr1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(ac1),
        .ResultSrc(rs1), .State(st1)
    );

    // ---------------- instance with MEM_LAT = 3 ----------------
    logic       rst3 = 1'b1;
    logic [3:0] op3  = 4'd0;
    logic       zero3 = 1'b0;
    logic       pcw3, irw3, mw3, rw3, adr3, sa3;
    logic [1:0] sb3, ac3, rs3;
    logic [3:0] st3;

    multi_cycle_controller #(.MEM_LAT(3)) u_dut3 (
        .CLK(CLK), .RESET(rst3), .Op(op3), .Zero(zero3),
        .PCWrite(pcw3), .IRWrite(irw3), .MemWrite(mw3), .RegWrite(rw3),
        .AdrSrc(adr3), .ALUSrcA(sa3), .ALUSrcB(sb3), .ALUControl(ac3),
        .ResultSrc(rs3), .State(st3)
    );

    // Observed vector: {State, PCWrite, IRWrite, MemWrite, RegWrite,
    //                   AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc}
    logic [15:0] w_obs1, w_obs3;
    assign w_obs1 = {st1, pcw1, irw1, mw1, rw1, adr1, sa1, sb1, ac1, rs1};
    assign w_obs3 = {st3, pcw3, irw3, mw3, rw3, adr3, sa3, sb3, ac3, rs3};

    int tests = 0;
    int fails = 0;

    logic [15:0] ev [0:31];
    int          ne;

    function automatic logic [15:0] ov(input logic [3:0] st, input logic pcw,
                                       input logic irw, input logic mw,
                                       input logic rw, input logic adr,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ac,
                                       input logic [1:0] rs);
        return {st, pcw, irw, mw, rw, adr, sa, sb, ac, rs};
    endfunction

    // Expected per-state vectors
    logic [15:0] c_f0, c_f1, c_dec, c_xm, c_mr, c_mwr, c_wbr, c_wbm, c_halt;
    initial begin
        c_f0   = ov(4'd0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10);
        c_f1   = ov(4'd0, 1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10);
        c_dec  = ov(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        c_xm   = ov(4'd3, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        c_mr   = ov(4'd4, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        c_mwr  = ov(4'd5, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        c_wbr  = ov(4'd6, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00);
        c_wbm  = ov(4'd7, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01);
        c_halt = ov(4'd9, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    end

    function automatic logic [15:0] xr(input logic [1:0] ac);
        return ov(4'd2, 0, 0, 0, 0, 0, 1, 2'b00, ac, 2'b00);
    endfunction

    function automatic logic [15:0] br(input logic pcw);
        return ov(4'd8, pcw, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Release the selected instance from reset, then compare ev[0..ne-1]
    // at successive negative edges (cycle 1 is the cycle right after release).
    task automatic run_trace(input bit sel3, input logic [3:0] op,
                             input logic zero, input string name);
        @(posedge CLK); #2;
        if (sel3) begin op3 = op; zero3 = zero; rst3 = 1'b0; end
        else      begin op1 = op; zero1 = zero; rst1 = 1'b0; end
        for (int i = 0; i < ne; i++) begin
            @(negedge CLK);
            check($sformatf("%s[%0d]", name, i + 1), sel3 ? w_obs3 : w_obs1, ev[i]);
        end
    endtask

    task automatic park();
        @(posedge CLK); #2;
        rst1 = 1'b1;
        rst3 = 1'b1;
    endtask

    initial begin
        // Reset state: FETCH with all enables low, even at MEM_LAT=1
        op1 = 4'b0000;
        #3;
        check("rst_l1", w_obs1, c_f0);
        check("rst_l3", w_obs3, c_f0);
        @(negedge CLK);
        check("rst_l1_edge", w_obs1, c_f0);

        // ADD, MEM_LAT=1: 0,1,2,6 then 0
        ev[0] = c_f1; ev[1] = c_dec; ev[2] = xr(2'b00); ev[3] = c_wbr; ev[4] = c_f1;
        ne = 5; run_trace(1'b0, 4'b0000, 1'b0, "add_l1"); park();

        // SUB and ORR select ALUControl = Op[1:0]
        ev[2] = xr(2'b01); run_trace(1'b0, 4'b0001, 1'b0, "sub_l1"); park();
        ev[2] = xr(2'b10); run_trace(1'b0, 4'b0010, 1'b0, "and_l1"); park();
        ev[2] = xr(2'b11); run_trace(1'b0, 4'b0011, 1'b0, "orr_l1"); park();

        // LDR, MEM_LAT=3: 9 cycles total, then FETCH again
        ev[0] = c_f0; ev[1] = c_f0; ev[2] = c_f1; ev[3] = c_dec; ev[4] = c_xm;
        ev[5] = c_mr; ev[6] = c_mr; ev[7] = c_mr; ev[8] = c_wbm; ev[9] = c_f0;
        ne = 10; run_trace(1'b1, 4'b0100, 1'b0, "ldr_l3"); park();

        // ADD, MEM_LAT=3: L+3 = 6 cycles
        ev[0] = c_f0; ev[1] = c_f0; ev[2] = c_f1; ev[3] = c_dec; ev[4] = xr(2'b00);
        ev[5] = c_wbr; ev[6] = c_f0;
        ne = 7; run_trace(1'b1, 4'b0000, 1'b0, "add_l3"); park();

        // STR, MEM_LAT=1: single MemWrite cycle, no RegWrite
        ev[0] = c_f1; ev[1] = c_dec; ev[2] = c_xm; ev[3] = c_mwr; ev[4] = c_f1;
        ne = 5; run_trace(1'b0, 4'b0101, 1'b0, "str_l1"); park();

        // LDR, MEM_LAT=1: 2L+3 = 5 cycles
        ev[0] = c_f1; ev[1] = c_dec; ev[2] = c_xm; ev[3] = c_mr; ev[4] = c_wbm;
        ev[5] = c_f1;
        ne = 6; run_trace(1'b0, 4'b0100, 1'b0, "ldr_l1"); park();

        // Branches
        ev[0] = c_f1; ev[1] = c_dec; ev[3] = c_f1; ne = 4;
        ev[2] = br(1'b1); run_trace(1'b0, 4'b0111, 1'b1, "beq_z1"); park();
        ev[2] = br(1'b0); run_trace(1'b0, 4'b0111, 1'b0, "beq_z0"); park();
        ev[2] = br(1'b1); run_trace(1'b0, 4'b0110, 1'b0, "b_z0");   park();
        ev[2] = br(1'b1); run_trace(1'b0, 4'b0110, 1'b1, "b_z1");   park();

        // NOP: FETCH, DECODE, FETCH
        ev[0] = c_f1; ev[1] = c_dec; ev[2] = c_f1;
        ne = 3; run_trace(1'b0, 4'b1010, 1'b0, "nop_l1"); park();

        // HALT: stays in state 9 for 20 cycles
        ev[0] = c_f1; ev[1] = c_dec;
        for (int i = 2; i < 22; i++) ev[i] = c_halt;
        ne = 22; run_trace(1'b0, 4'b1111, 1'b0, "halt_l1");
        #2; rst1 = 1'b1; #1;
        check("halt_async_rst", w_obs1, c_f0);
        park();

        // Reset mid-count in MEM_RD (MEM_LAT=3) aborts; Cnt restarts at 0
        ev[0] = c_f0; ev[1] = c_f0; ev[2] = c_f1; ev[3] = c_dec; ev[4] = c_xm;
        ev[5] = c_mr; ev[6] = c_mr;
        ne = 7; run_trace(1'b1, 4'b0100, 1'b0, "abort_l3");
        #2; rst3 = 1'b1; #1;
        check("abort_async", w_obs3, c_f0);
        @(posedge CLK); #1;
        check("abort_hold", w_obs3, c_f0);
        ev[0] = c_f0; ev[1] = c_f0; ev[2] = c_f1; ev[3] = c_dec;
        ne = 4; run_trace(1'b1, 4'b0100, 1'b0, "abort_restart"); park();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory access latency in cycles; legal range 1..8.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port RESET, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port Op, input, 4, opcode of the instruction held in the IR.
REQ-005 SHALL have port Zero, input, 1, ALU zero flag.
REQ-006 SHALL have outputs PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc and ALUSrcA, each 1 bit.
REQ-007 SHALL have outputs ALUSrcB[1:0], ALUControl[1:0] and ResultSrc[1:0]; ResultSrc drives the Select input of the 4:1 result mux.
REQ-008 SHALL have output State, 4 bits, the current state code for debug.

Function
REQ-009 SHALL implement a Moore FSM; outputs depend only on the state and the cycle counter Cnt, except the BRANCH PCWrite term in REQ-021.
REQ-010 SHALL use these state codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_M=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_M=7, BRANCH=8, HALT=9.
REQ-011 SHALL decode Op as follows:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR: R-type.
- 0100 LDR, 0101 STR: memory.
- 0110 B, 0111 BEQ: branch.
- 1111 HALT.
- All other codes: NOP.
REQ-012 SHALL drive default output values in every state: all enables 0, all selects 0, ALUControl 00. Each state overrides only the outputs listed for it.
REQ-013 FETCH SHALL drive AdrSrc=0, ALUSrcA=0, ALUSrcB=10 (constant 4), ALUControl=00 and ResultSrc=10.
REQ-014 FETCH SHALL hold for MEM_LAT cycles. IRWrite and PCWrite SHALL be 1 only on the last FETCH cycle (Cnt==MEM_LAT-1); the next state is then DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=01 and ALUControl=00 to form the branch target. Next state by class:
- R-type: EXEC_R
- memory: EXEC_M
- branch: BRANCH
- HALT: HALT
- NOP: FETCH
REQ-016 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUControl=Op[1:0]; next state is WB_R.
REQ-017 EXEC_M SHALL drive ALUSrcA=1, ALUSrcB=01 and ALUControl=00. Next state: MEM_RD for LDR, MEM_WR for STR.
REQ-018 MEM_RD SHALL drive AdrSrc=1 and hold for MEM_LAT cycles; next state is WB_M.
REQ-019 MEM_WR SHALL drive AdrSrc=1 and MemWrite=1 for exactly one cycle; next state is FETCH.
REQ-020 Writeback states SHALL drive the following, then go to FETCH:
- WB_R: RegWrite=1, ResultSrc=00 (ALUOut).
- WB_M: RegWrite=1, ResultSrc=01 (data register).
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUControl=01 and ResultSrc=00. PCWrite SHALL be 1 when Op==0110, or when Op==0111 and Zero==1. Next state is FETCH.
REQ-022 HALT SHALL drive all defaults and remain in HALT until RESET.
REQ-023 Cnt SHALL be a 3-bit counter:
- cleared on entry to FETCH and MEM_RD;
- incremented each cycle while in those states;
- unused elsewhere.
With MEM_LAT=1, FETCH and MEM_RD last one cycle.
REQ-024 ResultSrc=11 SHALL never be driven.
REQ-025 Latency per instruction SHALL be, with L=MEM_LAT:
- R-type: L+3
- LDR: 2L+3
- STR: L+3
- branch: L+2
- NOP: L+1

Reset
REQ-026 RESET high SHALL force the state to FETCH and Cnt to 0 immediately, without waiting for CLK.
REQ-027 While RESET is high, all enables (PCWrite, IRWrite, MemWrite, RegWrite) SHALL be 0, even when MEM_LAT=1.
REQ-028 The first FETCH cycle SHALL be the first CLK edge after RESET falls.
REQ-029 RESET asserted in any state, including mid-count in MEM_RD or in HALT, SHALL abort the operation with no further write enables.

Verification
REQ-030 MEM_LAT=1, Op=0000 -> states 0,1,2,6 then 0. IRWrite=PCWrite=1 in cycle 1, ALUControl=00 in EXEC_R, RegWrite=1 with ResultSrc=00 in cycle 4.
REQ-031 MEM_LAT=3, Op=0100 -> FETCH lasts 3 cycles with IRWrite only on the 3rd, MEM_RD lasts 3 cycles, WB_M has ResultSrc=01. Total 9 cycles.
REQ-032 Op=0111 -> Zero=1 in BRANCH gives PCWrite=1; Zero=0 gives PCWrite=0. Op=0110 gives PCWrite=1 regardless of Zero.
REQ-033 Op=0101 -> MemWrite=1 for exactly one cycle with AdrSrc=1, RegWrite never 1.
REQ-034 Op=1111 -> FSM stays at State=9 for 20 cycles with all enables 0. Asserting RESET between edges gives State=0 asynchronously.
REQ-035 Op=1010 (NOP) -> FETCH, DECODE, FETCH; no RegWrite or MemWrite.
